lcd_ctrl: RTL



---
 rtl/lcd_ctrl_if.sv | 19 +
 rtl/lcd_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_if.sv
// Write port between the LSU and the LCD controller: valid/ready with a 9-bit payload.
// wr_data[8] is RS (0 = command, 1 = data), wr_data[7:0] is the byte.
interface lcd_ctrl_if;
  logic       wr_vld;
  logic       wr_rdy;
  logic [8:0] wr_data;

  modport master (
    output wr_vld,
    output wr_data,
    input  wr_rdy
  );

  modport slave (
    input  wr_vld,
    input  wr_data,
    output wr_rdy
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD driver. Bytes posted on the write port are queued in a
// small FIFO and played out with setup / enable pulse / hold / execution-wait timing
// on io_lcd. A registered status word lets firmware poll for busy and full.
module lcd_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EN_CYC    = 12,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned CLEAR_CYC = 80000
) (
  input  logic        clk,
  input  logic        rst_n,
  lcd_ctrl_if.slave   wr,
  input  logic        lcd_on,
  output logic [31:0] status,
  output logic [31:0] io_lcd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } state_e;

  // FIFO storage and bookkeeping
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Sequencer state and registered outputs
  state_e        r_state;
  logic [31:0]   r_cnt;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_on;
  logic          r_busy;
  logic          r_full;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [8:0]    w_head;
  logic [CW-1:0] w_count_nxt;
  logic          w_going_idle;
  logic          w_long_cmd;
  logic [31:0]   w_wait_len;
  logic [7:0]    w_count8;

  // Ready is judged on the registered count only, so a pop in the same cycle never
  // frees a slot for a write that arrives while full.
  assign w_full      = (r_count == CW'(DEPTH));
  assign wr.wr_rdy   = rst_n && !w_full;
  assign w_push      = wr.wr_vld && wr.wr_rdy;
  assign w_pop       = (r_state == StIdle) && (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign w_long_cmd  = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
  assign w_wait_len  = w_long_cmd ? CLEAR_CYC : EXEC_CYC;

  // The FSM returns to IDLE next cycle either by staying idle or by finishing WAIT.
  assign w_going_idle = ((r_state == StIdle) && !w_pop) ||
                        ((r_state == StWait) && (r_cnt == 32'd0));

  assign w_count8 = 8'(r_count);
  assign status   = {16'b0, w_count8, 6'b0, r_full, r_busy};
  assign io_lcd   = {r_on, 20'b0, r_en, r_rs, 1'b0, r_data};

  // FIFO payload write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr.wr_data;
    end
  end

  // Sequencer, FIFO pointers/count and registered status/bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= StIdle;
      r_cnt    <= 32'd0;
      r_en     <= 1'b0;
      r_rs     <= 1'b0;
      r_data   <= 8'h00;
      r_on     <= 1'b0;
      r_busy   <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_on    <= lcd_on;
      r_count <= w_count_nxt;
      r_busy  <= !w_going_idle || (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_rs    <= w_head[8];
            r_data  <= w_head[7:0];
            r_cnt   <= SETUP_CYC - 1;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (r_cnt == 32'd0) begin
            r_en    <= 1'b1;
            r_cnt   <= EN_CYC - 1;
            r_state <= StPulse;
          end else begin
            r_cnt <= r_cnt - 1;
          end
        end
        StPulse: begin
          if (r_cnt == 32'd0) begin
            r_en    <= 1'b0;
            r_cnt   <= HOLD_CYC - 1;
            r_state <= StHold;
          end else begin
            r_cnt <= r_cnt - 1;
          end
        end
        StHold: begin
          if (r_cnt == 32'd0) begin
            r_cnt   <= w_wait_len - 1;
            r_state <= StWait;
          end else begin
            r_cnt <= r_cnt - 1;
          end
        end
        StWait: begin
          if (r_cnt == 32'd0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 1;
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
